// File: rtl/pipe_pkg.sv
// Shared definitions for the multi-pipe obstacle generator: game-state
// encodings, the LFSR feedback mask, default screen geometry and the gap
// height folding helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_PIP_WIDTH = 100;
  localparam int DEF_GAP_MIN   = 100;

  // Folds a 9-bit random value into [0, range). One subtraction suffices
  // because 2*range exceeds the largest 9-bit value.
  function automatic logic [8:0] fold_gap(input logic [8:0] r, input logic [8:0] range);
    return (r >= range) ? (r - range) : r;
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit right-shifting Galois LFSR used as the gap-height random source.
// Only the low nine bits are exported since that is all the gap logic uses.
module pipe_lfsr
  import pipe_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [8:0] o_rnd
);

  logic [15:0] r_lfsr;

  // Shift right; when the outgoing bit is set, fold the tap mask back in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign o_rnd = r_lfsr[8:0];

endmodule

// File: rtl/multi_pipe_generator.sv
// Multi-obstacle generator: NUM_PIPES slots that scroll left by STEP per
// tick, spawn at SCREEN_W+PIP_WIDTH every SPACING pixels into the lowest
// free slot, and retire once they fall off the left edge.
// Optional feature macro: PIPE_SCORE_EN enables the bird-crossing score pulse;
// without it score_pulse is a constant 0.
module multi_pipe_generator
  import pipe_pkg::*;
#(
  parameter int          NUM_PIPES = 3,
  parameter int          PIP_WIDTH = DEF_PIP_WIDTH,
  parameter int          GAP_MIN   = DEF_GAP_MIN,
  parameter int          SCREEN_W  = DEF_SCREEN_W,
  parameter int          SCREEN_H  = DEF_SCREEN_H,
  parameter int          SPACING   = 260,
  parameter int          STEP      = 1,
  parameter int          BIRD_X    = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk_2ms,
  input  logic                    rst_n,
  input  logic [1:0]              state,
  output logic [10*NUM_PIPES-1:0] pip_X,
  output logic [9*NUM_PIPES-1:0]  pip_Y,
  output logic [NUM_PIPES-1:0]    pip_valid,
  output logic                    score_pulse
);

  localparam int             TICKS      = SPACING / STEP;
  localparam int             CW         = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0]  CNT_RELOAD = CW'(TICKS - 1);
  localparam logic [9:0]     SPAWN_X    = 10'(SCREEN_W + PIP_WIDTH);
  localparam logic [9:0]     STEP_X     = 10'(STEP);
  localparam logic [8:0]     GAP_RANGE  = 9'(SCREEN_H - GAP_MIN);

  logic [8:0]           w_rnd;
  logic [8:0]           w_new_y;
  logic [NUM_PIPES-1:0] w_valid;
  logic [NUM_PIPES-1:0] w_free;
  logic [NUM_PIPES-1:0] w_sel;
  logic                 w_spawn_now;
  logic [CW-1:0]        r_spawn_cnt;

  // The random source runs in every state so the gap sequence keeps evolving.
  pipe_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (clk_2ms),
    .i_rst_n (rst_n),
    .i_en    (1'b1),
    .o_rnd   (w_rnd)
  );

  assign w_new_y = 9'(GAP_MIN) + fold_gap(w_rnd, GAP_RANGE);

  // Free-slot priority encoder: isolate the lowest clear valid bit. Uses the
  // valid vector from the start of the tick, so a slot retiring now waits.
  assign w_free      = ~w_valid;
  assign w_sel       = w_free & (~w_free + NUM_PIPES'(1));
  assign w_spawn_now = (state == ST_PLAY) && (r_spawn_cnt == '0) && (|w_free);

  // Spawn countdown: reload on spawn, hold at zero while all slots are busy.
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      r_spawn_cnt <= '0;
    end else begin
      case (state)
        ST_READY: r_spawn_cnt <= '0;
        ST_PLAY: begin
          if (r_spawn_cnt == '0) begin
            if (|w_free) r_spawn_cnt <= CNT_RELOAD;
          end else begin
            r_spawn_cnt <= r_spawn_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_SCORE_EN
  localparam logic [9:0] BIRD_XV = 10'(BIRD_X);
  logic [NUM_PIPES-1:0] w_cross;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
      logic [9:0] r_x;
      logic [8:0] r_y;
      logic       r_v;
      logic       w_spawn;
      logic [9:0] w_x_moved;

      assign w_spawn   = w_spawn_now & w_sel[gi];
      assign w_x_moved = r_x - STEP_X;

      // Slot update: clear in READY, spawn/scroll/retire in PLAY, hold otherwise.
      always_ff @(posedge clk_2ms or negedge rst_n) begin
        if (!rst_n) begin
          r_x <= '0;
          r_y <= 9'(GAP_MIN);
          r_v <= 1'b0;
        end else begin
          case (state)
            ST_READY: begin
              r_x <= '0;
              r_v <= 1'b0;
            end
            ST_PLAY: begin
              if (w_spawn) begin
                r_x <= SPAWN_X;
                r_y <= w_new_y;
                r_v <= 1'b1;
              end else if (r_v) begin
                if (r_x < STEP_X) begin
                  r_x <= '0;
                  r_v <= 1'b0;
                end else begin
                  r_x <= w_x_moved;
                end
              end
            end
            default: ;
          endcase
        end
      end

`ifdef PIPE_SCORE_EN
      // A live pipe crosses the bird when it moves from right of BIRD_X to on/left of it.
      assign w_cross[gi] = r_v && (r_x > BIRD_XV) && (w_x_moved <= BIRD_XV);
`endif

      assign w_valid[gi]          = r_v;
      assign pip_X[10*gi +: 10]   = r_x;
      assign pip_Y[9*gi +: 9]     = r_y;
    end
  endgenerate

  assign pip_valid = w_valid;

`ifdef PIPE_SCORE_EN
  logic r_score;

  // One registered pulse per tick in which any slot crosses the bird column.
  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= 1'b0;
    end else begin
      r_score <= (state == ST_PLAY) && (|w_cross);
    end
  end

  assign score_pulse = r_score;
`else
  // Scoring disabled: constant low, BIRD_X has no effect.
  assign score_pulse = 1'b0 & BIRD_X[0];
`endif

endmodule

// File: tb/tb_multi_pipe_generator.sv
// Directed bench for multi_pipe_generator. Three instances share clock,
// reset and state: defaults (a), one slot with SPACING=100 (b), STEP=4 (c).
module tb_multi_pipe_generator;

`ifdef PIPE_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  state;

  logic [29:0] a_x;  logic [26:0] a_y;  logic [2:0] a_v;  logic a_s;
  logic [9:0]  b_x;  logic [8:0]  b_y;  logic       b_v;  logic b_s;
  logic [29:0] c_x;  logic [26:0] c_y;  logic [2:0] c_v;  logic c_s;

  multi_pipe_generator dut_a (
    .clk_2ms(clk), .rst_n(rst_n), .state(state),
    .pip_X(a_x), .pip_Y(a_y), .pip_valid(a_v), .score_pulse(a_s)
  );

  multi_pipe_generator #(.NUM_PIPES(1), .SPACING(100)) dut_b (
    .clk_2ms(clk), .rst_n(rst_n), .state(state),
    .pip_X(b_x), .pip_Y(b_y), .pip_valid(b_v), .score_pulse(b_s)
  );

  multi_pipe_generator #(.STEP(4)) dut_c (
    .clk_2ms(clk), .rst_n(rst_n), .state(state),
    .pip_X(c_x), .pip_Y(c_y), .pip_valid(c_v), .score_pulse(c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    int          n;
    logic [2:0]  av;
    logic [29:0] ax;
    logic        asc;
    logic        bv;
    logic [9:0]  bx;
    logic [2:0]  cv;
    logic [29:0] cx;
  } vec_t;

  vec_t tbl[15];

  int n_cmp    = 0;
  int n_fail   = 0;
  int a_pulses = 0;
  int y_viol   = 0;

  function automatic vec_t mk(input logic [1:0] st, input int n,
                              input logic [2:0] av, input int a0, input int a1, input int a2,
                              input logic asc, input logic bv, input int bx,
                              input logic [2:0] cv, input int c0, input int c1, input int c2);
    vec_t v;
    v.st  = st;
    v.n   = n;
    v.av  = av;
    v.ax  = {10'(a2), 10'(a1), 10'(a0)};
    v.asc = asc & SCORE_EN;
    v.bv  = bv;
    v.bx  = 10'(bx);
    v.cv  = cv;
    v.cx  = {10'(c2), 10'(c1), 10'(c0)};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance n edges; after each, sample outputs and track pulses / gap range.
  task automatic tick(input int n);
    logic [8:0] y;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (a_s) a_pulses++;
      for (int i = 0; i < 3; i++) begin
        y = a_y[9*i +: 9];
        if (a_v[i] && (y < 9'd100 || y > 9'd479)) y_viol++;
        y = c_y[9*i +: 9];
        if (c_v[i] && (y < 9'd100 || y > 9'd479)) y_viol++;
      end
      if (b_v && (b_y < 9'd100 || b_y > 9'd479)) y_viol++;
    end
  endtask

  task automatic chk_reset(input string tag);
    logic [26:0] y3;
    y3 = {3{9'd100}};
    chk({tag, " a_v"}, 32'(a_v), 32'd0);
    chk({tag, " a_x"}, 32'(a_x), 32'd0);
    chk({tag, " a_y"}, 32'(a_y), 32'(y3));
    chk({tag, " a_s"}, 32'(a_s), 32'd0);
    chk({tag, " b_v"}, 32'(b_v), 32'd0);
    chk({tag, " b_x"}, 32'(b_x), 32'd0);
    chk({tag, " b_y"}, 32'(b_y), 32'd100);
    chk({tag, " b_s"}, 32'(b_s), 32'd0);
    chk({tag, " c_v"}, 32'(c_v), 32'd0);
    chk({tag, " c_y"}, 32'(c_y), 32'(y3));
    chk({tag, " c_s"}, 32'(c_s), 32'd0);
  endtask

  initial begin
    logic [26:0] save_ay;
    logic [8:0]  save_by;
    logic [26:0] save_cy;

    // Cumulative PLAY-tick timeline (T) noted per row.
    tbl[0]  = mk(2'd1,   1, 3'b001, 740,   0,   0, 1'b0, 1'b1, 740, 3'b001, 740,   0,   0); // T=1
    tbl[1]  = mk(2'd1, 259, 3'b001, 481,   0,   0, 1'b0, 1'b1, 481, 3'b101, 484,   0, 224); // T=260
    tbl[2]  = mk(2'd1,   1, 3'b011, 480, 740,   0, 1'b0, 1'b1, 480, 3'b111, 480, 740, 220); // T=261
    tbl[3]  = mk(2'd2,  50, 3'b011, 480, 740,   0, 1'b0, 1'b1, 480, 3'b111, 480, 740, 220); // frozen
    tbl[4]  = mk(2'd1,   1, 3'b011, 479, 739,   0, 1'b0, 1'b1, 479, 3'b111, 476, 736, 216); // T=262
    tbl[5]  = mk(2'd1, 258, 3'b011, 221, 481,   0, 1'b0, 1'b1, 221, 3'b011, 224, 484,   0); // T=520
    tbl[6]  = mk(2'd1,   1, 3'b111, 220, 480, 740, 1'b0, 1'b1, 220, 3'b111, 220, 480, 740); // T=521
    tbl[7]  = mk(2'd1,  19, 3'b111, 201, 461, 721, 1'b0, 1'b1, 201, 3'b111, 144, 404, 664); // T=540
    tbl[8]  = mk(2'd1,   1, 3'b111, 200, 460, 720, 1'b1, 1'b1, 200, 3'b111, 140, 400, 660); // T=541
    tbl[9]  = mk(2'd1, 200, 3'b111,   0, 260, 520, 1'b0, 1'b1,   0, 3'b111, 120, 380, 640); // T=741
    tbl[10] = mk(2'd1,   1, 3'b110,   0, 259, 519, 1'b0, 1'b0,   0, 3'b111, 116, 376, 636); // T=742
    tbl[11] = mk(2'd1,  38, 3'b110,   0, 221, 481, 1'b0, 1'b1, 703, 3'b110,   0, 224, 484); // T=780
    tbl[12] = mk(2'd1,   1, 3'b111, 740, 220, 480, 1'b0, 1'b1, 702, 3'b111, 740, 220, 480); // T=781
    tbl[13] = mk(2'd0,   1, 3'b000,   0,   0,   0, 1'b0, 1'b0,   0, 3'b000,   0,   0,   0); // READY
    tbl[14] = mk(2'd0,   5, 3'b000,   0,   0,   0, 1'b0, 1'b0,   0, 3'b000,   0,   0,   0);

    rst_n = 1'b0;
    state = 2'd0;
    #22;
    chk_reset("reset");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 15; i++) begin
      save_ay = a_y;
      save_by = b_y;
      save_cy = c_y;
      state = tbl[i].st;
      tick(tbl[i].n);
      chk($sformatf("row%0d a_v", i), 32'(a_v), 32'(tbl[i].av));
      chk($sformatf("row%0d a_x", i), 32'(a_x), 32'(tbl[i].ax));
      chk($sformatf("row%0d a_s", i), 32'(a_s), 32'(tbl[i].asc));
      chk($sformatf("row%0d b_v", i), 32'(b_v), 32'(tbl[i].bv));
      chk($sformatf("row%0d b_x", i), 32'(b_x), 32'(tbl[i].bx));
      chk($sformatf("row%0d c_v", i), 32'(c_v), 32'(tbl[i].cv));
      chk($sformatf("row%0d c_x", i), 32'(c_x), 32'(tbl[i].cx));
      if (tbl[i].st != 2'd1) begin
        chk($sformatf("row%0d a_y_held", i), 32'(a_y), 32'(save_ay));
        chk($sformatf("row%0d b_y_held", i), 32'(b_y), 32'(save_by));
        chk($sformatf("row%0d c_y_held", i), 32'(c_y), 32'(save_cy));
      end
    end

    chk("a_score_count", 32'(a_pulses), 32'(SCORE_EN ? 1 : 0));

    // Long PLAY run: gap heights must stay in range for every live slot.
    state = 2'd1;
    tick(10000);
    chk("y_range_violations", 32'(y_viol), 32'd0);
    chk("c_alive", 32'(c_v != 3'b000), 32'd1);
    chk("a_alive", 32'(a_v != 3'b000), 32'd1);

    // Asynchronous reset mid-PLAY must clear outputs before the next edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    #2;
    rst_n = 1'b1;
    state = 2'd0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
